// File: rtl/play_pkg.sv
// Shared types and score-word layout for the play-mode sequencer.
// The word is packed as {dur, notes, shift}, with shift in the LSBs.
package play_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
    GAP,
    FINISH
  } state_t;

  localparam int SHIFT_LSB = 0;
  localparam int END_DUR   = 0;

  function automatic int notes_lsb(input int shift_w);
    return SHIFT_LSB + shift_w;
  endfunction

  function automatic int dur_lsb(input int shift_w, input int note_w);
    return SHIFT_LSB + shift_w + note_w;
  endfunction

endpackage

// File: rtl/play_sequencer_tick.sv
// Tempo prescaler: counts 0..TICK_DIV-1 while run is high and flags the last count as a tick.
module tick_divider #(
  parameter int TICK_DIV = 6_250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = run && (count == LAST);

  // Holding (run low) keeps the partial tick so a resume continues where it stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/play_sequencer.sv
// Walks a stored score over a request/valid port and drives the tone generator,
// holding each note for its duration in tempo ticks with a silent gap between notes.
module play_sequencer
  import play_pkg::*;
#(
  parameter int NOTE_W    = 8,
  parameter int SHIFT_W   = 2,
  parameter int DUR_W     = 4,
  parameter int ADDR_W    = 7,
  parameter int TICK_DIV  = 6_250_000,
  parameter int GAP_TICKS = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        pause,
  input  logic                        loop,
  output logic                        rd_req,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic                        rd_valid,
  input  logic [DUR_W+NOTE_W+SHIFT_W-1:0] rd_data,
  output logic [NOTE_W-1:0]           notes,
  output logic [SHIFT_W-1:0]          shift,
  output logic                        sd,
  output logic                        busy,
  output logic                        done
);

  localparam int NOTES_LSB = notes_lsb(SHIFT_W);
  localparam int DUR_LSB   = dur_lsb(SHIFT_W, NOTE_W);
  localparam int GAP_W     = $clog2(GAP_TICKS + 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t              state;
  logic [DUR_W-1:0]    dur_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [NOTE_W-1:0]   note_lat;

  logic [DUR_W-1:0]    word_dur;
  logic [NOTE_W-1:0]   word_notes;
  logic [SHIFT_W-1:0]  word_shift;

  logic tick, presc_run, presc_clr;
  logic play_end, gap_end, next_fetch, end_hit;

  assign word_dur   = rd_data[DUR_LSB +: DUR_W];
  assign word_notes = rd_data[NOTES_LSB +: NOTE_W];
  assign word_shift = rd_data[SHIFT_LSB +: SHIFT_W];

  assign presc_run = ((state == PLAY) || (state == GAP)) && !pause;
  assign presc_clr = !en || !((state == PLAY) || (state == GAP));

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .run   (presc_run),
    .tick  (tick)
  );

  // A step past the last address counts as the end marker, so no wrapped read is issued.
  always_comb begin
    play_end   = (state == PLAY) && tick && (dur_cnt == DUR_W'(1));
    gap_end    = (state == GAP) && tick && (gap_cnt == GAP_W'(1));
    next_fetch = gap_end || (play_end && (GAP_TICKS == 0));
    end_hit    = ((state == FETCH) && rd_valid && (word_dur == DUR_W'(END_DUR)))
               || (next_fetch && (rd_addr == LAST_ADDR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dur_cnt  <= '0;
      gap_cnt  <= '0;
      note_lat <= '0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      notes    <= '0;
      shift    <= '0;
      sd       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (!en) begin
      state    <= IDLE;
      dur_cnt  <= '0;
      gap_cnt  <= '0;
      note_lat <= '0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      notes    <= '0;
      shift    <= '0;
      sd       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (end_hit) begin
        notes   <= '0;
        rd_addr <= '0;
        if (loop) begin
          state  <= FETCH;
          rd_req <= 1'b1;
          sd     <= !pause;
          busy   <= 1'b1;
        end else begin
          state  <= FINISH;
          rd_req <= 1'b0;
          shift  <= '0;
          sd     <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
      end else if (next_fetch) begin
        state   <= FETCH;
        rd_req  <= 1'b1;
        rd_addr <= rd_addr + ADDR_W'(1);
        notes   <= '0;
        sd      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state   <= FETCH;
            rd_req  <= 1'b1;
            rd_addr <= '0;
            sd      <= !pause;
            busy    <= 1'b1;
          end
          FETCH: begin
            sd <= !pause;
            if (rd_valid) begin
              state    <= PLAY;
              rd_req   <= 1'b0;
              dur_cnt  <= word_dur;
              note_lat <= word_notes;
              shift    <= word_shift;
              notes    <= pause ? '0 : word_notes;
            end
          end
          PLAY: begin
            sd <= !pause;
            if (play_end) begin
              state   <= GAP;
              gap_cnt <= GAP_W'(GAP_TICKS);
              notes   <= '0;
            end else begin
              if (tick) dur_cnt <= dur_cnt - DUR_W'(1);
              notes <= pause ? '0 : note_lat;
            end
          end
          GAP: begin
            sd    <= !pause;
            notes <= '0;
            if (tick) gap_cnt <= gap_cnt - GAP_W'(1);
          end
          FINISH: begin
            busy <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_play_sequencer.sv
// Bench for play_sequencer: directed scenarios plus random play, checked against a
// cycle-counting reference model of the score player.
module tb_play_sequencer;

  localparam int NOTE_W    = 8;
  localparam int SHIFT_W   = 2;
  localparam int DUR_W     = 4;
  localparam int ADDR_W    = 3;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;
  localparam int WORD_W    = DUR_W + NOTE_W + SHIFT_W;
  localparam int DEPTH     = 1 << ADDR_W;

  localparam int M_IDLE   = 0;
  localparam int M_FETCH  = 1;
  localparam int M_PLAY   = 2;
  localparam int M_GAP    = 3;
  localparam int M_FINISH = 4;

  logic clk = 1'b0;
  logic rst_n, en, pause, loop, rd_valid;
  logic [WORD_W-1:0]  rd_data;
  logic               rd_req;
  logic [ADDR_W-1:0]  rd_addr;
  logic [NOTE_W-1:0]  notes;
  logic [SHIFT_W-1:0] shift;
  logic sd, busy, done;

  play_sequencer #(
    .NOTE_W    (NOTE_W),
    .SHIFT_W   (SHIFT_W),
    .DUR_W     (DUR_W),
    .ADDR_W    (ADDR_W),
    .TICK_DIV  (TICK_DIV),
    .GAP_TICKS (GAP_TICKS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .pause    (pause),
    .loop     (loop),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .notes    (notes),
    .shift    (shift),
    .sd       (sd),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [WORD_W-1:0] score [DEPTH];
  int lat_mode, cur_lat, wait_cnt;
  int vectors, miscompares, done_seen, audible;

  int                 m_state, m_left;
  logic [ADDR_W-1:0]  m_addr;
  logic [NOTE_W-1:0]  m_note;
  logic               e_rd_req, e_sd, e_busy, e_done;
  logic [ADDR_W-1:0]  e_rd_addr;
  logic [NOTE_W-1:0]  e_notes;
  logic [SHIFT_W-1:0] e_shift;

  function automatic logic [WORD_W-1:0] mk(input int d, input int n, input int s);
    return {DUR_W'(d), NOTE_W'(n), SHIFT_W'(s)};
  endfunction

  task automatic pick_lat();
    cur_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_left = 0; m_addr = '0; m_note = '0;
    e_rd_req = 1'b0; e_rd_addr = '0; e_notes = '0; e_shift = '0;
    e_sd = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    wait_cnt = 0;
  endtask

  task automatic score_end();
    e_notes = '0;
    m_addr  = '0;
    if (loop) begin
      m_state = M_FETCH; e_rd_req = 1'b1;
    end else begin
      m_state = M_FINISH; e_rd_req = 1'b0; e_shift = '0;
      e_sd = 1'b0; e_busy = 1'b0; e_done = 1'b1;
    end
  endtask

  task automatic next_word();
    if (m_addr == ADDR_W'(DEPTH - 1)) begin
      score_end();
    end else begin
      m_addr = m_addr + 1'b1;
      m_state = M_FETCH; e_rd_req = 1'b1; e_notes = '0; e_sd = 1'b1;
    end
  endtask

  // Note and gap lengths are tracked as remaining unpaused cycles, not as ticks.
  task automatic model_step();
    int d;
    if (!en) begin
      model_reset();
      return;
    end
    e_done = 1'b0;
    case (m_state)
      M_IDLE: begin
        m_state = M_FETCH; m_addr = '0; e_rd_req = 1'b1; e_sd = !pause; e_busy = 1'b1;
      end
      M_FETCH: begin
        e_sd = !pause;
        if (rd_valid) begin
          d = int'(rd_data[WORD_W-1 -: DUR_W]);
          if (d == 0) begin
            score_end();
          end else begin
            m_state = M_PLAY; m_left = d * TICK_DIV;
            m_note  = rd_data[SHIFT_W +: NOTE_W];
            e_shift = rd_data[SHIFT_W-1:0];
            e_rd_req = 1'b0;
            e_notes = pause ? '0 : m_note;
          end
        end
      end
      M_PLAY: begin
        e_sd = !pause;
        if (!pause) m_left--;
        if (m_left == 0) begin
          m_state = M_GAP; m_left = GAP_TICKS * TICK_DIV; e_notes = '0;
        end else begin
          e_notes = pause ? '0 : m_note;
        end
      end
      M_GAP: begin
        e_sd = !pause;
        if (!pause) m_left--;
        if (m_left == 0) next_word();
      end
      default: ;
    endcase
    e_rd_addr = m_addr;
  endtask

  task automatic checkOutput();
    vectors++;
    assert (rd_req === e_rd_req) else begin
      miscompares++; $error("[TB] FAIL rd_req: got %0h expected %0h", rd_req, e_rd_req);
    end
    vectors++;
    assert (rd_addr === e_rd_addr) else begin
      miscompares++; $error("[TB] FAIL rd_addr: got %0h expected %0h", rd_addr, e_rd_addr);
    end
    vectors++;
    assert (notes === e_notes) else begin
      miscompares++; $error("[TB] FAIL notes: got %0h expected %0h", notes, e_notes);
    end
    vectors++;
    assert (shift === e_shift) else begin
      miscompares++; $error("[TB] FAIL shift: got %0h expected %0h", shift, e_shift);
    end
    vectors++;
    assert (sd === e_sd) else begin
      miscompares++; $error("[TB] FAIL sd: got %0h expected %0h", sd, e_sd);
    end
    vectors++;
    assert (busy === e_busy) else begin
      miscompares++; $error("[TB] FAIL busy: got %0h expected %0h", busy, e_busy);
    end
    vectors++;
    assert (done === e_done) else begin
      miscompares++; $error("[TB] FAIL done: got %0h expected %0h", done, e_done);
    end
  endtask

  // One clock: drive inputs and the memory response, advance the model, check at the negedge.
  task automatic applyStimulus(input logic en_v, input logic pause_v, input logic loop_v,
                               input logic force_valid);
    en = en_v; pause = pause_v; loop = loop_v;
    if (force_valid || (e_rd_req && wait_cnt >= cur_lat)) begin
      rd_valid = 1'b1; rd_data = score[e_rd_addr];
    end else begin
      rd_valid = 1'b0; rd_data = WORD_W'($urandom);
    end
    model_step();
    if (rd_valid || !e_rd_req) begin
      wait_cnt = 0;
      if (rd_valid) pick_lat();
    end else begin
      wait_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    if (done === 1'b1) done_seen++;
    if (notes !== '0) audible++;
    checkOutput();
  endtask

  task automatic run(input int n, input logic en_v, input logic pause_v, input logic loop_v);
    for (int i = 0; i < n; i++) applyStimulus(en_v, pause_v, loop_v, 1'b0);
  endtask

  task automatic set_lat(input int l);
    lat_mode = l; pick_lat(); wait_cnt = 0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; done_seen = 0; audible = 0;
    for (int i = 0; i < DEPTH; i++) score[i] = '0;
    rst_n = 1'b0; en = 1'b1; pause = 1'b0; loop = 1'b0; rd_valid = 1'b0; rd_data = '0;
    model_reset();
    set_lat(0);

    // Scenario 1: basic note, gap, end marker, done pulse
    score[0] = mk(2, 8'h01, 1); score[1] = mk(0, 0, 0);
    @(negedge clk);
    checkOutput();
    rst_n = 1'b1;
    run(25, 1'b1, 1'b0, 1'b0);
    vectors++;
    assert (done_seen == 1) else begin
      miscompares++; $error("[TB] FAIL done_count_s1: got %0d expected %0d", done_seen, 1);
    end
    run(2, 1'b0, 1'b0, 1'b0);

    $display("[TB] scenario 2: slow memory");
    set_lat(3);
    score[0] = mk(1, 8'h80, 2); score[1] = mk(0, 0, 0);
    run(25, 1'b1, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0, 1'b0);

    $display("[TB] scenario 3: pause mid-note");
    set_lat(0);
    score[0] = mk(3, 8'h24, 3); score[1] = mk(0, 0, 0);
    audible = 0;
    run(6, 1'b1, 1'b0, 1'b0);
    run(5, 1'b1, 1'b1, 1'b0);
    run(25, 1'b1, 1'b0, 1'b0);
    vectors++;
    assert (audible == 3 * TICK_DIV) else begin
      miscompares++; $error("[TB] FAIL audible_s3: got %0d expected %0d", audible, 3 * TICK_DIV);
    end
    run(2, 1'b0, 1'b0, 1'b0);

    $display("[TB] scenario 4: loop over a full score");
    set_lat(-1);
    for (int i = 0; i < DEPTH; i++)
      score[i] = mk($urandom_range(1, 2), 1 << (i % NOTE_W), i % 4);
    done_seen = 0;
    run(150, 1'b1, 1'b0, 1'b1);
    vectors++;
    assert (done_seen == 0) else begin
      miscompares++; $error("[TB] FAIL done_count_s4: got %0d expected %0d", done_seen, 0);
    end
    run(2, 1'b0, 1'b0, 1'b0);

    $display("[TB] scenario 5: en drop during fetch, late valid");
    set_lat(2);
    score[0] = mk(1, 8'h11, 2); score[1] = mk(0, 0, 0);
    run(2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    run(20, 1'b1, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0, 1'b0);

    $display("[TB] scenario 6: async reset mid-note");
    set_lat(0);
    score[0] = mk(4, 8'h42, 1); score[1] = mk(0, 0, 0);
    run(6, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    checkOutput();
    @(negedge clk);
    checkOutput();
    rst_n = 1'b1;
    run(2, 1'b0, 1'b0, 1'b0);
    run(25, 1'b1, 1'b0, 1'b0);

    $display("[TB] random play");
    set_lat(-1);
    for (int i = 0; i < DEPTH; i++)
      score[i] = mk(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 3),
                    $urandom_range(0, 255), $urandom_range(0, 3));
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 29) != 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 1) == 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/play_sequencer.md
# play_sequencer

Parametrised play-mode sequencer that walks a stored score and drives the existing tone generator's `notes`/`shift` inputs and the amplifier shutdown line. It fetches one score word at a time over a request/valid handshake and holds each note for a programmed number of tempo ticks, with an articulation gap between notes. It supports pause, loop and end-of-score, and reports `busy` and `done`. It replaces the single-word pass-through in the play path: the VGA/score store becomes the memory behind `rd_*`.

## Interface
- `NOTE_W`, 8: note-select field width (one-hot key lines to the tone generator).
- `SHIFT_W`, 2: octave-shift field width.
- `DUR_W`, 4: duration field width, in ticks.
- `ADDR_W`, 7: score address width; the score depth is 2^ADDR_W words.
- `TICK_DIV`, 6_250_000: clk cycles per tempo tick (1/16 s at 100 MHz). Must be ≥2.
- `GAP_TICKS`, 1: silent ticks after each note. 0 disables the gap.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `en` in 1: play mode selected (level).
- `pause` in 1: freeze playback (level).
- `loop` in 1: restart at address 0 after the end of the score.
- `rd_req` out 1: score read request.
- `rd_addr` out ADDR_W: score read address.
- `rd_valid` in 1: `rd_data` valid this cycle.
- `rd_data` in DUR_W+NOTE_W+SHIFT_W: score word, packed as {dur, notes, shift}, with `shift` in the LSBs.
- `notes` out NOTE_W: note lines to the tone generator.
- `shift` out SHIFT_W: octave shift to the tone generator.
- `sd` out 1: amplifier enable (1 = on).
- `busy` out 1: high when not in IDLE or FINISH.
- `done` out 1: one-cycle pulse when the end of the score is reached without loop.

## Operation
- States:
  - IDLE: silent.
  - FETCH: issue a read.
  - PLAY: sound the note.
  - GAP: silence between notes.
  - FINISH: score complete.
- Reset and IDLE values: all outputs 0, address 0, tick prescaler 0.
- IDLE → FETCH when `en`=1, with address 0.
- FETCH:
  - `rd_req`=1 and `rd_addr` stable until a cycle where `rd_valid`=1; the word is captured in that cycle.
  - If captured dur=0, it is the end marker → end handling.
  - Otherwise → PLAY. Load the duration counter with dur, latch notes/shift, clear the prescaler.
- PLAY:
  - Each tick decrements the duration counter.
  - When it reaches 0 → GAP if GAP_TICKS>0, else FETCH at addr+1.
- GAP: `notes`=0 and `shift` held. After GAP_TICKS ticks → FETCH at addr+1.
- Address wrap: an increment past 2^ADDR_W−1 is treated as the end marker. No read is issued for the wrapped address.
- End handling:
  - If `loop`=1: → FETCH at address 0.
  - Otherwise: → FINISH, with `done` pulsed for 1 cycle.
  - FINISH: silent, stays until `en`=0.
- Tick: prescaler counts 0..TICK_DIV−1 in PLAY/GAP only. A tick is the cycle where the count equals TICK_DIV−1 and `pause`=0.
- Pause:
  - Prescaler and counters hold; `notes`=0 and `sd`=0.
  - Latched note, address and state are retained; resume continues the interrupted tick.
  - In FETCH, the handshake proceeds normally; the captured note is not sounded until `pause`=0.
- `sd` = 1 in FETCH, PLAY and GAP when `pause`=0.
- `en`=0 in any state: next cycle → IDLE, all outputs 0, prescaler and address cleared. An outstanding `rd_req` is dropped, and a late `rd_valid` is ignored.
- Simultaneous `en` fall and end-of-score: `en` wins; no `done` pulse.

## Timing
- All outputs are registered.
- `rd_valid` cycle N → `notes`/`shift` valid and state PLAY at N+1.
- A note with dur=D is audible for exactly D·TICK_DIV cycles, excluding paused cycles.
- The gap lasts GAP_TICKS·TICK_DIV cycles.
- Minimum `rd_req` high time is 1 cycle; a zero-wait memory (`rd_valid` in the same cycle) is legal.
- End of PLAY/GAP → `rd_req` asserted the next cycle.
- `done` is asserted in the first FINISH cycle only.

## Structure
- Package `play_pkg`:
  - state enum (IDLE, FETCH, PLAY, GAP, FINISH);
  - field-offset localparams for the packed score word;
  - end-marker constant (dur=0).
- Sub-module `tick_divider`: parametrised by TICK_DIV, with inputs clk, rst_n, clr, run, and output `tick`.
- The tone generator stays outside; this block feeds it.

## Test plan
- Bench parameters for all scenarios: TICK_DIV=4, GAP_TICKS=1, ADDR_W=3.
1. Reset released with `en`=1, score {dur 2, notes 8'h01, shift 1}, {dur 0} → `notes`=01, `shift`=1 for 8 cycles; then 4 silent cycles; then `done` pulses once; FINISH with `busy`=0.
2. Memory `rd_valid` delayed 3 cycles → `rd_req`/`rd_addr` held stable for those cycles; `notes` updates exactly 1 cycle after `rd_valid`.
3. `pause` asserted for 5 cycles mid-note of dur 3 → `notes`=0 and `sd`=0 during the pause; total audible time is still 12 cycles.
4. `loop`=1 and all 8 words nonzero → address wraps 7→0, reads restart at 0, no `done` pulse.
5. `en` dropped while `rd_req`=1, then a late `rd_valid` → IDLE next cycle, all outputs 0, no note latched; `en` re-asserted → fetch restarts at address 0.
6. `rst_n` asserted mid-PLAY → outputs 0 immediately (asynchronous); after release, IDLE behaviour as in the reset values.
